// File: rtl/neuron_pkg.sv
// Shared types and helpers for the leaky integrate-and-fire neuron.
package neuron_pkg;

    localparam int DEFAULT_WIDTH    = 8;
    localparam int DEFAULT_REFRAC_W = 4;

    typedef enum logic {
        IDLE   = 1'b0,
        REFRAC = 1'b1
    } state_t;

    // Operands are zero-extended w-bit values (w < 32); add clamps at 2^w-1, sub floors at 0.
    function automatic logic [31:0] sat_add_sub(input logic [31:0] a,
                                                input logic [31:0] b,
                                                input logic        sub,
                                                input int unsigned w);
        logic [32:0] full;
        logic [32:0] max_v;
        max_v = (33'd1 << w) - 33'd1;
        if (sub) begin
            if (b > a) return 32'd0;
            return a - b;
        end
        full = {1'b0, a} + {1'b0, b};
        if (full > max_v) return max_v[31:0];
        return full[31:0];
    endfunction

endpackage

// File: rtl/neuron_weight_mux.sv
// NUM_WEIGHTS-to-1 weight selector; an index past the table yields zero.
module neuron_weight_mux
    import neuron_pkg::*;
#(
    parameter int WIDTH       = DEFAULT_WIDTH,
    parameter int NUM_WEIGHTS = 4,
    parameter int SEL_W       = $clog2(NUM_WEIGHTS)
) (
    input  logic [NUM_WEIGHTS*WIDTH-1:0] weights_i,
    input  logic [SEL_W-1:0]             sel_i,
    output logic [WIDTH-1:0]             weight_o
);

    always_comb begin
        weight_o = '0;
        for (int k = 0; k < NUM_WEIGHTS; k++) begin
            if (int'(sel_i) == k) weight_o = weights_i[k*WIDTH +: WIDTH];
        end
    end

endmodule

// File: rtl/neuron_lif_seq.sv
// Clocked leaky integrate-and-fire neuron with valid/ready event input and refractory period.
// Define NEURON_LIF_AUTOLEAK_EN to apply the leak on every idle cycle without an event.
module neuron_lif_seq
    import neuron_pkg::*;
#(
    parameter int WIDTH       = DEFAULT_WIDTH,
    parameter int NUM_WEIGHTS = 4,
    parameter int SEL_W       = $clog2(NUM_WEIGHTS),
    parameter int REFRAC_W    = DEFAULT_REFRAC_W
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         enable_i,
    input  logic                         in_valid_i,
    output logic                         in_ready_o,
    input  logic [SEL_W-1:0]             weight_select_i,
    input  logic [NUM_WEIGHTS*WIDTH-1:0] weights_i,
    input  logic [WIDTH-1:0]             leak_value_i,
    input  logic [WIDTH-1:0]             pos_threshold_i,
    input  logic [WIDTH-1:0]             neg_threshold_i,
    input  logic [WIDTH-1:0]             pos_reset_i,
    input  logic [WIDTH-1:0]             neg_reset_i,
    input  logic [REFRAC_W-1:0]          refrac_cycles_i,
    output logic [WIDTH-1:0]             potential_o,
    output logic                         spike_o,
    output logic                         out_valid_o
);

    function automatic logic [WIDTH-1:0] sat_add(input logic [WIDTH-1:0] a,
                                                 input logic [WIDTH-1:0] b);
        return WIDTH'(sat_add_sub(32'(a), 32'(b), 1'b0, WIDTH));
    endfunction

    function automatic logic [WIDTH-1:0] sat_sub(input logic [WIDTH-1:0] a,
                                                 input logic [WIDTH-1:0] b);
        return WIDTH'(sat_add_sub(32'(a), 32'(b), 1'b1, WIDTH));
    endfunction

    state_t              state_p1;
    logic [REFRAC_W-1:0] cnt_p1;
    logic [WIDTH-1:0]    potential_p1;
    logic                spike_p1;
    logic                vld_p1;

    logic [WIDTH-1:0]    w_p0;
    logic [WIDTH-1:0]    s_p0;
    logic [WIDTH-1:0]    t_p0;
    logic                fire_p0;
    logic                clamp_p0;
    logic                accept_p0;

    neuron_weight_mux #(
        .WIDTH      (WIDTH),
        .NUM_WEIGHTS(NUM_WEIGHTS),
        .SEL_W      (SEL_W)
    ) u_weight_mux (
        .weights_i(weights_i),
        .sel_i    (weight_select_i),
        .weight_o (w_p0)
    );

    // Stage p0: combinational update from the registered potential
    assign in_ready_o = rst_ni && enable_i && (state_p1 == IDLE);
    assign accept_p0  = in_valid_i && in_ready_o;
    assign s_p0       = sat_add(potential_p1, w_p0);
    assign t_p0       = sat_sub(s_p0, leak_value_i);
    assign fire_p0    = (t_p0 >= pos_threshold_i);
    assign clamp_p0   = (t_p0 <= neg_threshold_i);

    // Stage p1: registered neuron state and result pulses
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_p1     <= IDLE;
            cnt_p1       <= '0;
            potential_p1 <= '0;
            spike_p1     <= 1'b0;
            vld_p1       <= 1'b0;
        end else if (!enable_i) begin
            state_p1     <= IDLE;
            cnt_p1       <= '0;
            potential_p1 <= '0;
            spike_p1     <= 1'b0;
            vld_p1       <= 1'b0;
        end else begin
            spike_p1 <= 1'b0;
            vld_p1   <= 1'b0;
            case (state_p1)
                IDLE: begin
                    if (accept_p0) begin
                        vld_p1 <= 1'b1;
                        // Positive threshold is tested first so it wins on overlap
                        if (fire_p0) begin
                            potential_p1 <= pos_reset_i;
                            spike_p1     <= 1'b1;
                            if (refrac_cycles_i != '0) begin
                                state_p1 <= REFRAC;
                                cnt_p1   <= refrac_cycles_i;
                            end
                        end else if (clamp_p0) begin
                            potential_p1 <= neg_reset_i;
                        end else begin
                            potential_p1 <= t_p0;
                        end
                    end
`ifdef NEURON_LIF_AUTOLEAK_EN
                    else begin
                        potential_p1 <= sat_sub(potential_p1, leak_value_i);
                    end
`endif
                end
                REFRAC: begin
                    if (cnt_p1 == REFRAC_W'(1)) begin
                        state_p1 <= IDLE;
                        cnt_p1   <= '0;
                    end else begin
                        cnt_p1 <= cnt_p1 - 1'b1;
                    end
                end
                default: state_p1 <= IDLE;
            endcase
        end
    end

    assign potential_o = potential_p1;
    assign spike_o     = spike_p1;
    assign out_valid_o = vld_p1;

endmodule

// File: tb/tb_neuron_lif_seq.sv
// Directed self-checking bench for neuron_lif_seq (4-entry main instance, 3-entry range instance).
module tb_neuron_lif_seq;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        enable = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [1:0]  sel = '0;
    logic [31:0] weights = '0;
    logic [7:0]  leak = '0;
    logic [7:0]  pos_th = '0;
    logic [7:0]  neg_th = '0;
    logic [7:0]  pos_reset = '0;
    logic [7:0]  neg_reset = '0;
    logic [3:0]  refrac = '0;
    logic [7:0]  potential;
    logic        spike;
    logic        out_valid;

    logic        in_valid3 = 1'b0;
    logic        in_ready3;
    logic [1:0]  sel3 = '0;
    logic [23:0] weights3 = '0;
    logic [7:0]  potential3;
    logic        spike3;
    logic        out_valid3;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    neuron_lif_seq #(.WIDTH(8), .NUM_WEIGHTS(4), .REFRAC_W(4)) dut (
        .clk_i(clk), .rst_ni(rst_n), .enable_i(enable),
        .in_valid_i(in_valid), .in_ready_o(in_ready),
        .weight_select_i(sel), .weights_i(weights), .leak_value_i(leak),
        .pos_threshold_i(pos_th), .neg_threshold_i(neg_th),
        .pos_reset_i(pos_reset), .neg_reset_i(neg_reset),
        .refrac_cycles_i(refrac), .potential_o(potential),
        .spike_o(spike), .out_valid_o(out_valid)
    );

    neuron_lif_seq #(.WIDTH(8), .NUM_WEIGHTS(3), .REFRAC_W(4)) dut3 (
        .clk_i(clk), .rst_ni(rst_n), .enable_i(enable),
        .in_valid_i(in_valid3), .in_ready_o(in_ready3),
        .weight_select_i(sel3), .weights_i(weights3), .leak_value_i(leak),
        .pos_threshold_i(pos_th), .neg_threshold_i(neg_th),
        .pos_reset_i(pos_reset), .neg_reset_i(neg_reset),
        .refrac_cycles_i(refrac), .potential_o(potential3),
        .spike_o(spike3), .out_valid_o(out_valid3)
    );

    task automatic pulse();
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic pulse3();
        in_valid3 = 1'b1;
        @(posedge clk); #1;
        in_valid3 = 1'b0;
    endtask

    task automatic test_reset();
        enable = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (potential !== 8'd0) begin errors++; $display("FAIL reset_pot got=%0d exp=0", potential); end
        checks++; if (spike !== 1'b0) begin errors++; $display("FAIL reset_spike got=%b exp=0", spike); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", out_valid); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_ready got=%b exp=0", in_ready); end
        @(negedge clk) rst_n = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_release_ready got=%b exp=1", in_ready); end
    endtask

    task automatic test_basic();
        weights = {8'd0, 8'd15, 8'd20, 8'd36};
        sel = 2'd1; leak = 8'd2; pos_th = 8'd100; neg_th = 8'd0;
        pos_reset = 8'd5; neg_reset = 8'd0; refrac = 4'd0;
        pulse();
        checks++; if (potential !== 8'd18) begin errors++; $display("FAIL basic_pot got=%0d exp=18", potential); end
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL basic_valid got=%b exp=1", out_valid); end
        checks++; if (spike !== 1'b0) begin errors++; $display("FAIL basic_spike got=%b exp=0", spike); end
        @(posedge clk); #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL basic_valid_pulse got=%b exp=0", out_valid); end
        checks++; if (potential !== 8'd18) begin errors++; $display("FAIL basic_hold got=%0d exp=18", potential); end
    endtask

    task automatic test_back_to_back();
        in_valid = 1'b1;
        @(posedge clk); #1;
        checks++; if (potential !== 8'd36 || out_valid !== 1'b1) begin errors++; $display("FAIL b2b_first got=%0d/%b exp=36/1", potential, out_valid); end
        @(posedge clk); #1;
        checks++; if (potential !== 8'd54 || out_valid !== 1'b1) begin errors++; $display("FAIL b2b_second got=%0d/%b exp=54/1", potential, out_valid); end
        in_valid = 1'b0;
        @(posedge clk); #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_idle_valid got=%b exp=0", out_valid); end
    endtask

    task automatic test_spike_refrac();
        sel = 2'd0; leak = 8'd0;
        pulse();
        checks++; if (potential !== 8'd90) begin errors++; $display("FAIL refrac_setup got=%0d exp=90", potential); end
        sel = 2'd2; refrac = 4'd3;
        pulse();
        checks++; if (spike !== 1'b1 || out_valid !== 1'b1) begin errors++; $display("FAIL refrac_spike got=%b/%b exp=1/1", spike, out_valid); end
        checks++; if (potential !== 8'd5) begin errors++; $display("FAIL refrac_pot got=%0d exp=5", potential); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL refrac_ready0 got=%b exp=0", in_ready); end
        // Later edits to refrac must not shorten the running count; a held event must be ignored
        refrac = 4'd0; sel = 2'd0; in_valid = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            @(posedge clk); #1;
            checks++; if (in_ready !== (i == 3)) begin errors++; $display("FAIL refrac_ready%0d got=%b exp=%b", i, in_ready, (i == 3)); end
            checks++; if (potential !== 8'd5 || out_valid !== 1'b0 || spike !== 1'b0) begin errors++; $display("FAIL refrac_hold%0d got=%0d/%b/%b exp=5/0/0", i, potential, out_valid, spike); end
        end
        in_valid = 1'b0;
    endtask

    task automatic test_saturation();
        weights = {8'd0, 8'd0, 8'd20, 8'd245};
        pos_th = 8'd255; neg_th = 8'd0; leak = 8'd0; sel = 2'd0;
        pulse();
        checks++; if (potential !== 8'd250 || spike !== 1'b0) begin errors++; $display("FAIL sat_setup got=%0d/%b exp=250/0", potential, spike); end
        pos_reset = 8'd250; sel = 2'd1;
        pulse();
        checks++; if (spike !== 1'b1 || potential !== 8'd250) begin errors++; $display("FAIL sat_spike got=%b/%0d exp=1/250", spike, potential); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL sat_no_refrac_ready got=%b exp=1", in_ready); end
        leak = 8'd44;
        pulse();
        checks++; if (potential !== 8'd211 || spike !== 1'b0 || out_valid !== 1'b1) begin errors++; $display("FAIL sat_leak got=%0d/%b/%b exp=211/0/1", potential, spike, out_valid); end
    endtask

    task automatic test_floor_clamp();
        weights = {8'd0, 8'd8, 8'd20, 8'd0};
        sel = 2'd0; leak = 8'd208;
        pulse();
        checks++; if (potential !== 8'd3) begin errors++; $display("FAIL floor_setup got=%0d exp=3", potential); end
        leak = 8'd10; neg_reset = 8'd7;
        pulse();
        checks++; if (potential !== 8'd7 || spike !== 1'b0 || out_valid !== 1'b1) begin errors++; $display("FAIL floor_clamp got=%0d/%b/%b exp=7/0/1", potential, spike, out_valid); end
        // Overlapping thresholds: t=15 is both >=10 and <=20
        leak = 8'd0; sel = 2'd2; pos_th = 8'd10; neg_th = 8'd20; pos_reset = 8'd9;
        pulse();
        checks++; if (spike !== 1'b1 || potential !== 8'd9) begin errors++; $display("FAIL overlap got=%b/%0d exp=1/9", spike, potential); end
    endtask

    task automatic test_enable_refrac();
        weights = {8'd200, 8'd0, 8'd0, 8'd0};
        pos_th = 8'd100; neg_th = 8'd0; refrac = 4'd5; pos_reset = 8'd60; sel = 2'd3;
        pulse();
        checks++; if (spike !== 1'b1 || potential !== 8'd60 || in_ready !== 1'b0) begin errors++; $display("FAIL en_spike got=%b/%0d/%b exp=1/60/0", spike, potential, in_ready); end
        @(posedge clk); #1;
        enable = 1'b0; in_valid = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL en_low_ready got=%b exp=0", in_ready); end
        @(posedge clk); #1;
        checks++; if (potential !== 8'd0 || out_valid !== 1'b0 || spike !== 1'b0) begin errors++; $display("FAIL en_clear got=%0d/%b/%b exp=0/0/0", potential, out_valid, spike); end
        in_valid = 1'b0; enable = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL en_reenable_ready got=%b exp=1", in_ready); end
        @(posedge clk); #1;
        checks++; if (potential !== 8'd0 || out_valid !== 1'b0) begin errors++; $display("FAIL en_hold got=%0d/%b exp=0/0", potential, out_valid); end
    endtask

    task automatic test_async_reset();
        weights = {8'd0, 8'd0, 8'd0, 8'd50};
        sel = 2'd0; pos_th = 8'd200; neg_th = 8'd0; leak = 8'd0;
        pulse();
        checks++; if (potential !== 8'd50) begin errors++; $display("FAIL arst_setup got=%0d exp=50", potential); end
        in_valid = 1'b1;
        @(posedge clk); #1;
        checks++; if (potential !== 8'd100 || out_valid !== 1'b1) begin errors++; $display("FAIL arst_event got=%0d/%b exp=100/1", potential, out_valid); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (potential !== 8'd0 || out_valid !== 1'b0 || spike !== 1'b0 || in_ready !== 1'b0) begin errors++; $display("FAIL arst_clear got=%0d/%b/%b/%b exp=0/0/0/0", potential, out_valid, spike, in_ready); end
        in_valid = 1'b0;
        @(negedge clk) rst_n = 1'b1;
    endtask

    task automatic test_sel_range();
        weights3 = {8'd200, 8'd200, 8'd50};
        pos_th = 8'd255; neg_th = 8'd0; leak = 8'd0; sel3 = 2'd0;
        pulse3();
        checks++; if (potential3 !== 8'd50) begin errors++; $display("FAIL range_setup got=%0d exp=50", potential3); end
        sel3 = 2'd3; leak = 8'd5;
        pulse3();
        checks++; if (potential3 !== 8'd45 || out_valid3 !== 1'b1) begin errors++; $display("FAIL range_oob got=%0d/%b exp=45/1", potential3, out_valid3); end
        sel3 = 2'd2; leak = 8'd0;
        pulse3();
        checks++; if (potential3 !== 8'd245 || spike3 !== 1'b0) begin errors++; $display("FAIL range_last got=%0d/%b exp=245/0", potential3, spike3); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_spike_refrac();
        test_saturation();
        test_floor_clamp();
        test_enable_refrac();
        test_async_reset();
        test_sel_range();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
